// File: rtl/ex_accumulator.sv
// Expand-stage output accumulator: sums per-lane partial products over channel groups,
// rounds, saturates and hands each pixel out through a one-entry valid/ready register.
// Build option: define EX_ACC_RELU_EN to clamp negative lanes to zero before saturation.
module ex_accumulator #(
  parameter int Data_Width = 14,
  parameter int LANES      = 16,
  parameter int PROD_W     = 32,
  parameter int ACC_W      = 36,
  parameter int FRAC_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  channel_groups,
  input  logic                        in_valid,
  input  logic [LANES*PROD_W-1:0]     in_data,
  input  logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*Data_Width-1:0] out_data,
  output logic                        busy,
  output logic                        err_overrun,
  output logic                        err_partial
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // One extra bit of headroom so adding the rounding constant never wraps.
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2**(FRAC_BITS-1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(Data_Width-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_W:0] ZERO    = '0;

  state_t                     state_r;
  logic                       busy_r;
  logic [3:0]                 groups_r;
  logic [3:0]                 cnt_r;
  logic signed [ACC_W-1:0]    acc_r [LANES];
  logic                       out_valid_r;
  logic [LANES*Data_Width-1:0] out_data_r;
  logic                       err_overrun_r;
  logic                       err_partial_r;

  logic signed [ACC_W-1:0]    sum_s [LANES];
  logic [LANES*Data_Width-1:0] result_s;
  logic [3:0]                 groups_s;
  logic                       beat_s;
  logic                       last_s;
  logic                       complete_s;
  logic [3:0]                 cnt_next_s;

  function automatic logic [Data_Width-1:0] form_lane(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] sat;
    ext = {sum[ACC_W-1], sum} + RND;
    r   = ext >>> FRAC_BITS;
`ifdef EX_ACC_RELU_EN
    if (r < ZERO) begin
      r = ZERO;
    end else begin
      r = r;
    end
`endif
    if (r > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (r < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = r;
    end
    return sat[Data_Width-1:0];
  endfunction

  // Lane sums, formatted results and beat bookkeeping for the current cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_s[i] = acc_r[i] + {{(ACC_W-PROD_W){in_data[i*PROD_W+PROD_W-1]}},
                             in_data[i*PROD_W +: PROD_W]};
      result_s[i*Data_Width +: Data_Width] = form_lane(sum_s[i]);
    end
    groups_s   = (channel_groups == 4'd0) ? 4'd1 : channel_groups;
    beat_s     = (state_r == ACCUM) && in_valid && !start;
    last_s     = (cnt_r == (groups_r - 4'd1));
    complete_s = beat_s && last_s;
    if (complete_s) begin
      cnt_next_s = 4'd0;
    end else if (beat_s) begin
      cnt_next_s = cnt_r + 4'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Control state, group count and per-lane accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      groups_r      <= 4'd1;
      cnt_r         <= 4'd0;
      err_partial_r <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_r[i] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= ACCUM;
            busy_r   <= 1'b1;
            groups_r <= groups_s;
            cnt_r    <= 4'd0;
            for (int i = 0; i < LANES; i++) acc_r[i] <= '0;
          end
        end
        ACCUM: begin
          if (start) begin
            groups_r <= groups_s;
            cnt_r    <= 4'd0;
            for (int i = 0; i < LANES; i++) acc_r[i] <= '0;
          end else if (done) begin
            // A same-cycle beat counts first; anything still partial is dropped.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 4'd0;
            if (cnt_next_s != 4'd0) err_partial_r <= 1'b1;
            for (int i = 0; i < LANES; i++) acc_r[i] <= '0;
          end else begin
            cnt_r <= cnt_next_s;
            for (int i = 0; i < LANES; i++) begin
              if (complete_s) acc_r[i] <= '0;
              else if (beat_s) acc_r[i] <= sum_s[i];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register; a completion that finds it full is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      err_overrun_r <= 1'b0;
    end else if (complete_s) begin
      if (!out_valid_r || out_ready) begin
        out_valid_r <= 1'b1;
        out_data_r  <= result_s;
      end else begin
        err_overrun_r <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign busy        = busy_r;
  assign err_overrun = err_overrun_r;
  assign err_partial = err_partial_r;

endmodule

// File: tb/tb_ex_accumulator.sv
// Randomized and directed self-checking bench for ex_accumulator against a
// plain-arithmetic per-pixel reference model.
module tb_ex_accumulator;
  localparam int DW = 14;
  localparam int L  = 16;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, done, out_ready;
  logic [3:0]        channel_groups;
  logic [L*PW-1:0]   in_data;
  logic              out_valid, busy, err_overrun, err_partial;
  logic [L*DW-1:0]   out_data;

  int total = 0;
  int bad   = 0;
  int exp_l [L];
  logic [L*DW-1:0] expq [$];

  ex_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .channel_groups(channel_groups),
    .in_valid(in_valid), .in_data(in_data), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .err_overrun(err_overrun), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  // Reference: round half up by floor division, optional clamp, then saturate.
  function automatic int ref_lane(longint s);
    longint t, q;
    t = s + 64'sd128;
    q = t / 64'sd256;
    if (t < 0 && (t % 64'sd256) != 0) q = q - 64'sd1;
`ifdef EX_ACC_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 64'sd8191) q = 64'sd8191;
    if (q < -64'sd8192) q = -64'sd8192;
    return int'(q);
  endfunction

  function automatic logic [L*DW-1:0] pack_exp();
    logic [L*DW-1:0] p;
    for (int i = 0; i < L; i++) begin
      int t;
      t = exp_l[i];
      p[i*DW +: DW] = t[DW-1:0];
    end
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; done = 1'b0; out_ready = 1'b1;
    channel_groups = 4'd0; in_data = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic start_pixel(input int g);
    start = 1'b1; channel_groups = 4'(g);
    cyc();
    start = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < L; i++) exp_l[i] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({out_valid, busy, err_overrun, err_partial} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, busy, err_overrun, err_partial}); end
    total++; if (out_data !== '0) begin
      bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
  endtask

  task automatic test_single_group();
    do_reset();
    start_pixel(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    in_data = '0; in_data[0 +: PW] = 32'd1280; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    clear_exp(); exp_l[0] = ref_lane(64'sd1280);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL single_data: got %h expected %h", out_data, pack_exp()); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_three_groups();
    int beats [3] = '{25600, 51200, 76800};
    do_reset();
    start_pixel(3);
    for (int b = 0; b < 3; b++) begin
      in_data = '0; in_data[0 +: PW] = beats[b]; in_valid = 1'b1;
      cyc();
      if (b < 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL three_early_valid beat %0d: got %b expected 0", b, out_valid); end
      end
    end
    in_valid = 1'b0;
    clear_exp(); exp_l[0] = ref_lane(64'sd153600);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL three_valid: got %b expected 1", out_valid); end
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL three_data: got %h expected %h", out_data, pack_exp()); end
  endtask

  task automatic test_round_sat();
    int vals [5] = '{128, -129, 3000000, -3000000, -1280};
    do_reset();
    start_pixel(1);
    in_data = '0; clear_exp();
    for (int i = 0; i < 5; i++) begin
      in_data[i*PW +: PW] = vals[i];
      exp_l[i] = ref_lane(longint'(vals[i]));
    end
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL round_sat: got %h expected %h", out_data, pack_exp()); end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    start_pixel(1);
    in_data = '0; in_data[0 +: PW] = 32'd256; in_valid = 1'b1;
    cyc();
    in_data[0 +: PW] = 32'd512;
    cyc();
    in_valid = 1'b0;
    clear_exp(); exp_l[0] = ref_lane(64'sd256);
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL overrun_data: got %h expected %h", out_data, pack_exp()); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b expected 1", err_overrun); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL overrun_drain: got %b expected 0", out_valid); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b expected 1", err_overrun); end
  endtask

  task automatic test_partial_end();
    do_reset();
    start_pixel(4);
    in_data = '0; in_data[0 +: PW] = 32'd100; in_valid = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0; done = 1'b1;
    cyc();
    done = 1'b0;
    total++; if ({err_partial, busy, out_valid} !== 3'b100) begin
      bad++; $display("FAIL partial_flags: got %b expected 100", {err_partial, busy, out_valid}); end
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++; if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL partial_ignore cyc %0d: got %b expected 00", k, {busy, out_valid}); end
    end
    in_valid = 1'b0;
    // A beat alongside done that finishes the pixel still produces a result.
    do_reset();
    start_pixel(1);
    in_data = '0; in_data[0 +: PW] = 32'd768; in_valid = 1'b1; done = 1'b1;
    cyc();
    in_valid = 1'b0; done = 1'b0;
    clear_exp(); exp_l[0] = ref_lane(64'sd768);
    total++; if ({out_valid, err_partial, busy} !== 3'b100) begin
      bad++; $display("FAIL done_complete_flags: got %b expected 100", {out_valid, err_partial, busy}); end
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL done_complete_data: got %h expected %h", out_data, pack_exp()); end
  endtask

  task automatic test_restart();
    do_reset();
    out_ready = 1'b0;
    start_pixel(2);
    in_data = '0; in_data[0 +: PW] = 32'd1000; in_valid = 1'b1;
    cyc();
    start = 1'b1; channel_groups = 4'd1; in_data[0 +: PW] = 32'd9999;
    cyc();
    start = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_discard: got %b expected 0", out_valid); end
    in_data[0 +: PW] = 32'd512; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    clear_exp(); exp_l[0] = ref_lane(64'sd512);
    total++; if (out_data !== pack_exp()) begin bad++; $display("FAIL restart_data: got %h expected %h", out_data, pack_exp()); end
    start_pixel(2);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL restart_pending: got %b expected 1", out_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if ({out_valid, busy, err_overrun, err_partial} !== 4'b0000 || out_data !== '0) begin
      bad++; $display("FAIL midrun_reset: got flags %b data %h expected 0000 and 0",
                      {out_valid, busy, err_overrun, err_partial}, out_data); end
  endtask

  task automatic rand_tick();
    cyc();
    if (out_valid) begin
      total++;
      if (expq.size() == 0) begin
        bad++; $display("FAIL random_unexpected: got valid %h expected no output", out_data);
      end else begin
        logic [L*DW-1:0] e;
        e = expq.pop_front();
        if (out_data !== e) begin bad++; $display("FAIL random_data: got %h expected %h", out_data, e); end
      end
    end
  endtask

  task automatic test_random();
    longint acc [L];
    do_reset();
    expq.delete();
    for (int p = 0; p < 30; p++) begin
      int g, ge;
      g  = $urandom_range(0, 5);
      ge = (g == 0) ? 1 : g;
      start = 1'b1; channel_groups = 4'(g);
      rand_tick();
      start = 1'b0;
      for (int i = 0; i < L; i++) acc[i] = 0;
      for (int b = 0; b < ge; b++) begin
        if ($urandom_range(0, 3) == 0) rand_tick();
        for (int i = 0; i < L; i++) begin
          int v;
          v = $urandom_range(0, 8388607);
          v = v - 4194304;
          in_data[i*PW +: PW] = v;
          acc[i] = acc[i] + longint'(v);
        end
        in_valid = 1'b1;
        if (b == ge - 1) begin
          for (int i = 0; i < L; i++) exp_l[i] = ref_lane(acc[i]);
          expq.push_back(pack_exp());
        end
        rand_tick();
        in_valid = 1'b0;
      end
    end
    rand_tick(); rand_tick();
    total++; if (expq.size() != 0) begin bad++; $display("FAIL random_missing: got %0d outstanding expected 0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_three_groups();
    test_round_sat();
    test_overrun();
    test_partial_end();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
